// File: rtl/regfile_wr_arbiter_if.sv
// Write-port bus between the writeback requesters (master) and the register
// file write arbiter (slave): per-requester valid/ready/addr/data plus the registered write port.
interface regfile_wr_arbiter_if #(
  parameter int NREQ = 2,
  parameter int AW   = 5,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [DW-1:0]      wr_data;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin owner of the register file write port, with an optional clear sweep of r1..r31 after reset.
// Optional stall counter output is enabled by defining REGFILE_WR_ARB_STATS_EN.
module regfile_wr_arbiter #(
  parameter int NREQ           = 2,
  parameter int AW             = 5,
  parameter int DW             = 32,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  elk,
  input  logic                  nrst,
  regfile_wr_arbiter_if.slave   bus,
  output logic                  init_done,
`ifdef REGFILE_WR_ARB_STATS_EN
  output logic [15:0]           stall_cnt,
`endif
  output logic                  zero_drop
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_FIN  = 2'd1;
  localparam logic [1:0] ST_ARB  = 2'd2;

  localparam logic [AW-1:0] LAST_ADDR = AW'(31);

  logic [1:0]    state;
  logic [AW-1:0] clr_cnt;
  logic [PW-1:0] rr;
  logic [PW-1:0] grant_idx;
  logic [PW-1:0] cand;
  logic          grant_valid;
  logic [NREQ-1:0] ready;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic [AW-1:0] addr_arr [NREQ];
  logic [DW-1:0] data_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_arr[i] = bus.req_addr[i*AW +: AW];
    assign data_arr[i] = bus.req_data[i*DW +: DW];
  end

  // Search from the rr pointer, wrapping; only the first valid requester is granted.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    sel_addr    = '0;
    sel_data    = '0;
    ready       = '0;
    if (state == ST_ARB) begin
      for (int k = 0; k < NREQ; k++) begin
        cand = PW'((int'(rr) + k) % NREQ);
        if (!grant_valid && bus.req_valid[cand]) begin
          grant_valid = 1'b1;
          grant_idx   = cand;
          sel_addr    = addr_arr[cand];
          sel_data    = data_arr[cand];
        end
      end
    end
    if (grant_valid) ready[grant_idx] = 1'b1;
  end

  assign bus.req_ready = ready;

  // ST_FIN keeps ready low while the addr-31 sweep write is on the port, so the
  // first arbitrated write can never land in the same cycle as init_done rising.
  always_ff @(posedge elk or negedge nrst) begin
    if (!nrst) begin
      state       <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_ARB;
      clr_cnt     <= AW'(1);
      rr          <= '0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      zero_drop   <= 1'b0;
      init_done   <= (CLEAR_ON_RESET == 0);
    end else begin
      bus.wr_en <= 1'b0;
      zero_drop <= 1'b0;
      case (state)
        ST_INIT: begin
          bus.wr_en   <= 1'b1;
          bus.wr_addr <= clr_cnt;
          bus.wr_data <= '0;
          clr_cnt     <= clr_cnt + AW'(1);
          if (clr_cnt == LAST_ADDR) state <= ST_FIN;
        end
        ST_FIN: begin
          state     <= ST_ARB;
          init_done <= 1'b1;
        end
        default: begin
          if (grant_valid) begin
            rr <= (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + PW'(1);
            if (sel_addr == '0) begin
              zero_drop <= 1'b1;
            end else begin
              bus.wr_en   <= 1'b1;
              bus.wr_addr <= sel_addr;
              bus.wr_data <= sel_data;
            end
          end
        end
      endcase
    end
  end

`ifdef REGFILE_WR_ARB_STATS_EN
  // Counts arbitration cycles where some requester is left waiting; saturates.
  always_ff @(posedge elk or negedge nrst) begin
    if (!nrst) begin
      stall_cnt <= '0;
    end else if (state == ST_ARB && |(bus.req_valid & ~ready) && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
Owns the single write port of the 32x32 register file and shares it between NREQ writeback requesters using round-robin arbitration and a valid/ready handshake. After reset it first runs a clear sweep that writes zero to r1..r31, so the register file reaches a known state through its normal write port. Writes to r0 are accepted and discarded, and the block flags each one. Sits between the execute/load writeback stages and the register file's wr_en/wr_addr/wr_data inputs.

Parameters:
NREQ, 2, number of writeback requesters (2..4)
AW, 5, register address width
DW, 32, register data width
CLEAR_ON_RESET, 1, 1 = run clear sweep after reset; 0 = go straight to arbitration

Ports:
elk  input  1  clock, all state updates on rising edge
nrst  input  1  asynchronous active-low reset
req_valid  input  NREQ  per-requester write request
req_ready  output  NREQ  per-requester accept (combinational)
req_addr  input  NREQ*AW  packed destination addresses, requester i at [i*AW +: AW]
req_data  input  NREQ*DW  packed write data, requester i at [i*DW +: DW]
wr_en  output  1  register file write enable (registered)
wr_addr  output  AW  register file write address (registered)
wr_data  output  DW  register file write data (registered)
init_done  output  1  high once the clear sweep is finished (registered)
zero_drop  output  1  one-cycle pulse when an r0 write is discarded (registered)

Behaviour:
- Reset (nrst=0, asynchronous):
  - state=INIT (or ARB if CLEAR_ON_RESET=0), clear counter=1, rr pointer=0.
  - wr_en=0, wr_addr=0, wr_data=0, zero_drop=0.
  - init_done=0 (or 1 if CLEAR_ON_RESET=0).
- Reset asserted mid-sweep or mid-write: everything returns to the reset values above. The sweep restarts from r1 after nrst rises.
- INIT state:
  - Each cycle: wr_en=1, wr_addr=counter, wr_data=0, and the counter increments.
  - The sweep covers r1..r31, 31 consecutive write cycles, and never writes r0.
  - req_ready=0 for all requesters.
  - On the cycle after the counter=31 write is issued: state=ARB, init_done=1, wr_en=0.
- ARB state, grant:
  - Combinational search starting at the rr pointer, wrapping mod NREQ. The first requester with req_valid=1 is granted.
  - req_ready[i]=1 only for the granted requester and only in ARB.
  - At most one ready bit is high in any cycle.
- Handshake rules:
  - A transfer occurs when req_valid[i] & req_ready[i] at a rising edge.
  - A requester holds valid, addr and data stable until accepted; it may not withdraw valid.
- Write issue:
  - On transfer, the next cycle has wr_en=1, wr_addr=req_addr[i], wr_data=req_data[i].
  - Accept-to-wr_en latency is 1 cycle.
  - Throughput is one write per cycle, and back-to-back accepts are allowed.
  - With no transfer, wr_en=0; wr_addr and wr_data hold their last values.
- r0 write: the transfer completes (ready=1), wr_en stays 0 the next cycle, and zero_drop=1 for that one cycle.
- Pointer update: after a transfer from requester i, pointer=(i+1) mod NREQ. With no transfer, the pointer holds.
- Fairness: a continuously valid requester is granted within NREQ transfers.
- Registers are updated only via this port, and all outputs are registered except req_ready.

Optional Feature:
- Macro REGFILE_WR_ARB_STATS_EN.
- When defined: adds output stall_cnt (16 bits, reset 0).
  - In ARB, it increments by 1 each cycle in which some req_valid[j]=1 has req_ready[j]=0.
  - It saturates at 16'hFFFF and does not count during INIT.
- When undefined: port and counter are absent, and behaviour is otherwise identical.

Test Plan:
- Sweep: release nrst with CLEAR_ON_RESET=1 -> wr_en=1 for exactly 31 cycles with wr_addr 1..31 and wr_data=0; init_done rises the cycle after the addr-31 write; req_ready=0 throughout, even with req_valid=2'b11.
- Single write: after init, req0 valid with addr=5, data=32'hDEADBEEF -> req_ready[0]=1 that cycle; next cycle wr_en=1, wr_addr=5, wr_data=DEADBEEF; following cycle wr_en=0.
- Round-robin: both requesters valid for 4 transfers, pointer=0, req0 addr=3, req1 addr=4 -> grant order 0,1,0,1; wr_addr sequence 3,4,3,4 on consecutive cycles.
- r0 drop: req1 valid with addr=0, data=32'h12345678 -> accepted, wr_en stays 0, zero_drop=1 for one cycle, and the pointer advances to 0.
- Reset mid-sweep: pull nrst low at sweep address 10, release two cycles later -> outputs go to 0 immediately while nrst is low; the sweep restarts at wr_addr=1 and again issues 31 writes.
- Stats (macro defined): hold both valids for 6 cycles -> 6 transfers and stall_cnt=6; preload near saturation (force count) -> it stays at FFFF.
